axi4l_arbiter_2to1: RTL and testbench
=====================================

Name: axi4l_arbiter_2to1

Overview:
- Two-master to one-slave AXI4-Lite arbiter in front of shared peripherals such as the mtime/mtimecmp timer.
- Lets the Ibex data port (s0) and the debug/DMA port (s1) share one slave.
- Read and write directions are arbitrated independently, with one outstanding transaction per direction.
- Slave-side responses are routed back only to the granted master.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate priority after each completed grant; 0 = s0 always wins ties.

Ports:
- clk  input  1  single clock for all logic; the interfaces' aclk/aresetn are unused.
- rst  input  1  asynchronous, active-high reset.
- s0  axi4l_if.slave  axi4l_pkg widths (addr_t, 32-bit data, strb_t, resp_t)  requester 0.
- s1  axi4l_if.slave  same  requester 1.
- m  axi4l_if.master  same  shared downstream slave.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - rst is asynchronous, active-high.
  - All state and grant registers clear on rst assertion and reset to FSM IDLE, grant = s0, prio = s0.
- Outputs during reset and in IDLE:
  - All ready/valid outputs are 0 on both master sides and the slave side.
  - This holds combinationally, because every output is qualified by FSM state.
- Write FSM: W_IDLE -> W_BUSY -> W_RESP -> W_IDLE.
  - W_IDLE:
    - Request = sN.awvalid.
    - If one requests, register wgrant = that master.
    - If both request: ROUND_ROBIN=1 picks the master ≠ wprio; ROUND_ROBIN=0 picks s0.
    - Next state W_BUSY; clear aw_done and w_done.
    - The decision costs one cycle; no handshake completes in W_IDLE.
  - W_BUSY:
    - m.aw* and m.w* are muxed from the granted master.
    - m.awvalid = sel.awvalid && !aw_done; m.wvalid = sel.wvalid && !w_done.
    - sel.awready = m.awready && !aw_done; sel.wready = m.wready && !w_done.
    - Set aw_done / w_done on the respective m handshake.
    - AW and W may complete in either order or in the same cycle.
    - When both are done (including the completing cycle), go to W_RESP.
  - W_RESP:
    - m.bready = sel.bready; sel.bvalid = m.bvalid; sel.bresp = m.bresp.
    - On the b handshake: wprio = wgrant, then W_IDLE.
- Read FSM: R_IDLE -> R_ADDR -> R_RESP -> R_IDLE.
  - Same grant rule on sN.arvalid, using its own rgrant and rprio.
  - R_ADDR: m.ar* muxed from the granted master; on the ar handshake go to R_RESP.
  - R_RESP: m.rready = sel.rready; sel.rvalid/rdata/rresp = m.*; on the r handshake update rprio and go to R_IDLE.
- Non-granted master and idle directions:
  - All of the non-granted master's ready and valid outputs are 0; its requests are held off (it keeps valid asserted per AXI).
  - m.*valid = 0 in any state where its channel is not forwarded.
  - Data and address outputs pass the granted master's values unregistered; no data storage inside the arbiter.
- Latency: +1 cycle per address phase (grant cycle); zero added on data and response paths.
- Boundary conditions:
  - Read and write may be granted to different masters simultaneously, since the two FSMs are independent.
  - A requester dropping awvalid in W_IDLE before the grant registers is a protocol violation and is not handled.
  - sN.bvalid/rvalid are never asserted to a master without its own prior address handshake.
  - Reset mid-transaction returns both FSMs to IDLE immediately; the partial transaction is dropped (downstream is reset by the same event).

Test Plan:
1. s0 alone writes 0x12345678, awaddr 0x008 (strb 0xF) → m sees the write one cycle after awvalid; s0.bvalid with OKAY; s1 ready/valid stay 0.
2. s0 and s1 assert arvalid on the same cycle, ROUND_ROBIN=1, after reset → s1 is granted first (prio = s0). Then s0, with the r responses mtime low/high routed to the correct master. With ROUND_ROBIN=0 → s0 first.
3. s0 write with W preceding AW by 3 cycles, m.awready held low 2 cycles → exactly one m AW and one m W handshake; a single b returned.
4. Concurrent s0 write to 0x00C and s1 read of 0x000 → both complete in overlapping cycles, with no channel crossover.
5. m.bvalid held with s1.bready low for 5 cycles → m.bready low for 5 cycles; no new write grant until the b handshake.
6. rst asserted in W_BUSY after AW done but before W → all valids/readys drop to 0 asynchronously; after release both FSMs are IDLE and a fresh s0 write completes normally.

Source files
------------

// File: rtl/axi4l_arbiter_2to1.sv
// axi4l_arbiter_2to1: two-master to one-slave AXI4-Lite arbiter with independent read/write grant FSMs.
module axi4l_arbiter_2to1 #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s0_awvalid_i,
    output logic                s0_awready_o,
    input  logic [ADDR_W-1:0]   s0_awaddr_i,
    input  logic [2:0]          s0_awprot_i,
    input  logic                s0_wvalid_i,
    output logic                s0_wready_o,
    input  logic [DATA_W-1:0]   s0_wdata_i,
    input  logic [DATA_W/8-1:0] s0_wstrb_i,
    output logic                s0_bvalid_o,
    input  logic                s0_bready_i,
    output logic [1:0]          s0_bresp_o,
    input  logic                s0_arvalid_i,
    output logic                s0_arready_o,
    input  logic [ADDR_W-1:0]   s0_araddr_i,
    input  logic [2:0]          s0_arprot_i,
    output logic                s0_rvalid_o,
    input  logic                s0_rready_i,
    output logic [DATA_W-1:0]   s0_rdata_o,
    output logic [1:0]          s0_rresp_o,
    input  logic                s1_awvalid_i,
    output logic                s1_awready_o,
    input  logic [ADDR_W-1:0]   s1_awaddr_i,
    input  logic [2:0]          s1_awprot_i,
    input  logic                s1_wvalid_i,
    output logic                s1_wready_o,
    input  logic [DATA_W-1:0]   s1_wdata_i,
    input  logic [DATA_W/8-1:0] s1_wstrb_i,
    output logic                s1_bvalid_o,
    input  logic                s1_bready_i,
    output logic [1:0]          s1_bresp_o,
    input  logic                s1_arvalid_i,
    output logic                s1_arready_o,
    input  logic [ADDR_W-1:0]   s1_araddr_i,
    input  logic [2:0]          s1_arprot_i,
    output logic                s1_rvalid_o,
    input  logic                s1_rready_i,
    output logic [DATA_W-1:0]   s1_rdata_o,
    output logic [1:0]          s1_rresp_o,
    output logic                m_awvalid_o,
    input  logic                m_awready_i,
    output logic [ADDR_W-1:0]   m_awaddr_o,
    output logic [2:0]          m_awprot_o,
    output logic                m_wvalid_o,
    input  logic                m_wready_i,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    input  logic                m_bvalid_i,
    output logic                m_bready_o,
    input  logic [1:0]          m_bresp_i,
    output logic                m_arvalid_o,
    input  logic                m_arready_i,
    output logic [ADDR_W-1:0]   m_araddr_o,
    output logic [2:0]          m_arprot_o,
    input  logic                m_rvalid_i,
    output logic                m_rready_o,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic [1:0]          m_rresp_i
);
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_t;

    w_state_t wstate_q;
    r_state_t rstate_q;
    logic     wgnt_q, wprio_q, aw_done_q, w_done_q, rgnt_q, rprio_q;
    logic     w_busy, w_resp, r_addr, r_resp;
    logic     aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, b_hs, ar_hs, r_hs, wpick, rpick;

    assign w_busy = wstate_q == W_BUSY;
    assign w_resp = wstate_q == W_RESP;
    assign r_addr = rstate_q == R_ADDR;
    assign r_resp = rstate_q == R_RESP;

    // On a tie, round robin favours the master that did not win last time.
    assign wpick = (s0_awvalid_i && s1_awvalid_i) ? (ROUND_ROBIN ? !wprio_q : 1'b0) : s1_awvalid_i;
    assign rpick = (s0_arvalid_i && s1_arvalid_i) ? (ROUND_ROBIN ? !rprio_q : 1'b0) : s1_arvalid_i;

    assign m_awvalid_o = w_busy && !aw_done_q && (wgnt_q ? s1_awvalid_i : s0_awvalid_i);
    assign m_awaddr_o  = wgnt_q ? s1_awaddr_i : s0_awaddr_i;
    assign m_awprot_o  = wgnt_q ? s1_awprot_i : s0_awprot_i;
    assign m_wvalid_o  = w_busy && !w_done_q && (wgnt_q ? s1_wvalid_i : s0_wvalid_i);
    assign m_wdata_o   = wgnt_q ? s1_wdata_i : s0_wdata_i;
    assign m_wstrb_o   = wgnt_q ? s1_wstrb_i : s0_wstrb_i;
    assign m_bready_o  = w_resp && (wgnt_q ? s1_bready_i : s0_bready_i);
    assign aw_rdy      = w_busy && !aw_done_q && m_awready_i;
    assign w_rdy       = w_busy && !w_done_q && m_wready_i;
    assign s0_awready_o = aw_rdy && !wgnt_q;
    assign s1_awready_o = aw_rdy && wgnt_q;
    assign s0_wready_o  = w_rdy && !wgnt_q;
    assign s1_wready_o  = w_rdy && wgnt_q;
    assign s0_bvalid_o  = w_resp && !wgnt_q && m_bvalid_i;
    assign s1_bvalid_o  = w_resp && wgnt_q && m_bvalid_i;
    assign s0_bresp_o   = m_bresp_i;
    assign s1_bresp_o   = m_bresp_i;

    assign m_arvalid_o = r_addr && (rgnt_q ? s1_arvalid_i : s0_arvalid_i);
    assign m_araddr_o  = rgnt_q ? s1_araddr_i : s0_araddr_i;
    assign m_arprot_o  = rgnt_q ? s1_arprot_i : s0_arprot_i;
    assign m_rready_o  = r_resp && (rgnt_q ? s1_rready_i : s0_rready_i);
    assign ar_rdy      = r_addr && m_arready_i;
    assign s0_arready_o = ar_rdy && !rgnt_q;
    assign s1_arready_o = ar_rdy && rgnt_q;
    assign s0_rvalid_o  = r_resp && !rgnt_q && m_rvalid_i;
    assign s1_rvalid_o  = r_resp && rgnt_q && m_rvalid_i;
    assign s0_rdata_o   = m_rdata_i;
    assign s1_rdata_o   = m_rdata_i;
    assign s0_rresp_o   = m_rresp_i;
    assign s1_rresp_o   = m_rresp_i;

    assign aw_hs = m_awvalid_o && m_awready_i;
    assign w_hs  = m_wvalid_o && m_wready_i;
    assign b_hs  = m_bvalid_i && m_bready_o;
    assign ar_hs = m_arvalid_o && m_arready_i;
    assign r_hs  = m_rvalid_i && m_rready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            wgnt_q    <= 1'b0;
            wprio_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (wstate_q == W_IDLE) begin
            if (s0_awvalid_i || s1_awvalid_i) begin
                wgnt_q    <= wpick;
                wstate_q  <= W_BUSY;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
        end else if (w_busy) begin
            aw_done_q <= aw_done_q || aw_hs;
            w_done_q  <= w_done_q || w_hs;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                wstate_q <= W_RESP;
        end else if (b_hs || !w_resp) begin
            wprio_q  <= wgnt_q;
            wstate_q <= W_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rgnt_q   <= 1'b0;
            rprio_q  <= 1'b0;
        end else if (rstate_q == R_IDLE) begin
            if (s0_arvalid_i || s1_arvalid_i) begin
                rgnt_q   <= rpick;
                rstate_q <= R_ADDR;
            end
        end else if (r_addr) begin
            if (ar_hs)
                rstate_q <= R_RESP;
        end else if (r_hs || !r_resp) begin
            rprio_q  <= rgnt_q;
            rstate_q <= R_IDLE;
        end
    end
endmodule

// File: tb/tb_axi4l_arbiter_2to1.sv
// tb_axi4l_arbiter_2to1: directed checks of grant order, routing, stalls and async reset.
module tb_axi4l_arbiter_2to1;
    logic        clk, rst;
    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] s0_awaddr, s0_araddr, s0_wdata, s0_rdata, s1_awaddr, s1_araddr, s1_wdata, s1_rdata;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [3:0]  s0_wstrb, s1_wstrb, m_wstrb;
    logic [2:0]  s0_awprot, s0_arprot, s1_awprot, s1_arprot, m_awprot, m_arprot;
    logic [1:0]  s0_bresp, s0_rresp, s1_bresp, s1_rresp, m_bresp, m_rresp;
    logic        fp_s0_awready, fp_s0_wready, fp_s0_bvalid, fp_s0_arready, fp_s0_rvalid;
    logic        fp_s1_awready, fp_s1_wready, fp_s1_bvalid, fp_s1_arready, fp_s1_rvalid;
    logic        fp_m_awvalid, fp_m_wvalid, fp_m_bready, fp_m_arvalid, fp_m_rready;
    logic [31:0] fp_s0_rdata, fp_s1_rdata, fp_m_awaddr, fp_m_wdata, fp_m_araddr;
    logic [3:0]  fp_m_wstrb;
    logic [2:0]  fp_m_awprot, fp_m_arprot;
    logic [1:0]  fp_s0_bresp, fp_s0_rresp, fp_s1_bresp, fp_s1_rresp;
    int          nv = 0, nf = 0, aw_n = 0, w_n = 0, aw0, w0;

    axi4l_arbiter_2to1 #(.ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .s0_awvalid_i(s0_awvalid), .s0_awready_o(s0_awready), .s0_awaddr_i(s0_awaddr), .s0_awprot_i(s0_awprot),
        .s0_wvalid_i(s0_wvalid), .s0_wready_o(s0_wready), .s0_wdata_i(s0_wdata), .s0_wstrb_i(s0_wstrb),
        .s0_bvalid_o(s0_bvalid), .s0_bready_i(s0_bready), .s0_bresp_o(s0_bresp),
        .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready), .s0_araddr_i(s0_araddr), .s0_arprot_i(s0_arprot),
        .s0_rvalid_o(s0_rvalid), .s0_rready_i(s0_rready), .s0_rdata_o(s0_rdata), .s0_rresp_o(s0_rresp),
        .s1_awvalid_i(s1_awvalid), .s1_awready_o(s1_awready), .s1_awaddr_i(s1_awaddr), .s1_awprot_i(s1_awprot),
        .s1_wvalid_i(s1_wvalid), .s1_wready_o(s1_wready), .s1_wdata_i(s1_wdata), .s1_wstrb_i(s1_wstrb),
        .s1_bvalid_o(s1_bvalid), .s1_bready_i(s1_bready), .s1_bresp_o(s1_bresp),
        .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready), .s1_araddr_i(s1_araddr), .s1_arprot_i(s1_arprot),
        .s1_rvalid_o(s1_rvalid), .s1_rready_i(s1_rready), .s1_rdata_o(s1_rdata), .s1_rresp_o(s1_rresp),
        .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(m_awaddr), .m_awprot_o(m_awprot),
        .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
        .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .m_bresp_i(m_bresp),
        .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr), .m_arprot_o(m_arprot),
        .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp)
    );

    axi4l_arbiter_2to1 #(.ROUND_ROBIN(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .s0_awvalid_i(s0_awvalid), .s0_awready_o(fp_s0_awready), .s0_awaddr_i(s0_awaddr), .s0_awprot_i(s0_awprot),
        .s0_wvalid_i(s0_wvalid), .s0_wready_o(fp_s0_wready), .s0_wdata_i(s0_wdata), .s0_wstrb_i(s0_wstrb),
        .s0_bvalid_o(fp_s0_bvalid), .s0_bready_i(s0_bready), .s0_bresp_o(fp_s0_bresp),
        .s0_arvalid_i(s0_arvalid), .s0_arready_o(fp_s0_arready), .s0_araddr_i(s0_araddr), .s0_arprot_i(s0_arprot),
        .s0_rvalid_o(fp_s0_rvalid), .s0_rready_i(s0_rready), .s0_rdata_o(fp_s0_rdata), .s0_rresp_o(fp_s0_rresp),
        .s1_awvalid_i(s1_awvalid), .s1_awready_o(fp_s1_awready), .s1_awaddr_i(s1_awaddr), .s1_awprot_i(s1_awprot),
        .s1_wvalid_i(s1_wvalid), .s1_wready_o(fp_s1_wready), .s1_wdata_i(s1_wdata), .s1_wstrb_i(s1_wstrb),
        .s1_bvalid_o(fp_s1_bvalid), .s1_bready_i(s1_bready), .s1_bresp_o(fp_s1_bresp),
        .s1_arvalid_i(s1_arvalid), .s1_arready_o(fp_s1_arready), .s1_araddr_i(s1_araddr), .s1_arprot_i(s1_arprot),
        .s1_rvalid_o(fp_s1_rvalid), .s1_rready_i(s1_rready), .s1_rdata_o(fp_s1_rdata), .s1_rresp_o(fp_s1_rresp),
        .m_awvalid_o(fp_m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(fp_m_awaddr), .m_awprot_o(fp_m_awprot),
        .m_wvalid_o(fp_m_wvalid), .m_wready_i(m_wready), .m_wdata_o(fp_m_wdata), .m_wstrb_o(fp_m_wstrb),
        .m_bvalid_i(m_bvalid), .m_bready_o(fp_m_bready), .m_bresp_i(m_bresp),
        .m_arvalid_o(fp_m_arvalid), .m_arready_i(m_arready), .m_araddr_o(fp_m_araddr), .m_arprot_o(fp_m_arprot),
        .m_rvalid_i(m_rvalid), .m_rready_o(fp_m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        aw_n <= aw_n + int'(m_awvalid && m_awready);
        w_n  <= w_n + int'(m_wvalid && m_wready);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nv++;
        assert (obs === exp) else begin
            nf++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {s0_awvalid, s0_wvalid, s0_bready, s0_arvalid, s0_rready} = '0;
        {s1_awvalid, s1_wvalid, s1_bready, s1_arvalid, s1_rready} = '0;
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        {s0_awaddr, s0_araddr, s0_wdata, s1_awaddr, s1_araddr, s1_wdata, m_rdata} = '0;
        {s0_wstrb, s1_wstrb, s0_awprot, s0_arprot, s1_awprot, s1_arprot, m_bresp, m_rresp} = '0;
        tick;
        chk("rst_m_awvalid", m_awvalid, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_s0_bvalid", s0_bvalid, 0);
        chk("rst_s1_rvalid", s1_rvalid, 0);
        rst = 1'b0;
        tick;

        // 1: s0 lone write
        s0_awvalid = 1; s0_awaddr = 32'h8; s0_wvalid = 1; s0_wdata = 32'h12345678; s0_wstrb = 4'hF;
        s0_bready = 1; m_awready = 1; m_wready = 1;
        #1 chk("t1_idle_awvalid", m_awvalid, 0);
        chk("t1_idle_awready", s0_awready, 0);
        tick;
        chk("t1_m_awvalid", m_awvalid, 1);
        chk("t1_m_awaddr", m_awaddr, 32'h8);
        chk("t1_m_wvalid", m_wvalid, 1);
        chk("t1_m_wdata", m_wdata, 32'h12345678);
        chk("t1_m_wstrb", m_wstrb, 4'hF);
        chk("t1_s0_ready", {s0_awready, s0_wready}, 2'b11);
        chk("t1_s1_ready", {s1_awready, s1_wready}, 2'b00);
        tick;
        s0_awvalid = 0; s0_wvalid = 0; m_bvalid = 1; m_bresp = 2'b00;
        #1 chk("t1_resp_awvalid", m_awvalid, 0);
        chk("t1_s0_bvalid", s0_bvalid, 1);
        chk("t1_s0_bresp", s0_bresp, 2'b00);
        chk("t1_s1_bvalid", s1_bvalid, 0);
        chk("t1_m_bready", m_bready, 1);
        tick;
        m_bvalid = 0;
        #1 chk("t1_done_bvalid", s0_bvalid, 0);

        // 2: simultaneous reads, round robin vs fixed priority
        s0_arvalid = 1; s0_araddr = 32'h0; s1_arvalid = 1; s1_araddr = 32'h4;
        s0_rready = 1; s1_rready = 1; m_arready = 1;
        #1 chk("t2_idle_arvalid", m_arvalid, 0);
        tick;
        chk("t2_rr_araddr", m_araddr, 32'h4);
        chk("t2_rr_arready", {s1_arready, s0_arready}, 2'b10);
        chk("t2_fp_araddr", fp_m_araddr, 32'h0);
        chk("t2_fp_arready", {fp_s1_arready, fp_s0_arready}, 2'b01);
        tick;
        s1_arvalid = 0; m_rvalid = 1; m_rdata = 32'hAAAA0004;
        #1 chk("t2_s1_rvalid", s1_rvalid, 1);
        chk("t2_s1_rdata", s1_rdata, 32'hAAAA0004);
        chk("t2_s0_rvalid_held", s0_rvalid, 0);
        chk("t2_m_rready", m_rready, 1);
        tick;
        m_rvalid = 0;
        #1 chk("t2_idle2_arvalid", m_arvalid, 0);
        tick;
        chk("t2_s0_araddr", m_araddr, 32'h0);
        chk("t2_s0_arready", {s1_arready, s0_arready}, 2'b01);
        tick;
        s0_arvalid = 0; m_rvalid = 1; m_rdata = 32'h55550000;
        #1 chk("t2_s0_rvalid", s0_rvalid, 1);
        chk("t2_s0_rdata", s0_rdata, 32'h55550000);
        chk("t2_s1_rvalid_held", s1_rvalid, 0);
        tick;
        m_rvalid = 0;

        // 3: W leads AW by 3 cycles, AW stalled 2 cycles downstream
        aw0 = aw_n; w0 = w_n;
        m_awready = 0; s0_wvalid = 1; s0_wdata = 32'hCAFEF00D; s0_wstrb = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_w_only_wvalid", m_wvalid, 0);
            chk("t3_w_only_wready", s0_wready, 0);
            tick;
        end
        s0_awvalid = 1; s0_awaddr = 32'hC;
        #1 chk("t3_idle_awvalid", m_awvalid, 0);
        tick;
        chk("t3_b1_valids", {m_awvalid, m_wvalid}, 2'b11);
        chk("t3_b1_readys", {s0_awready, s0_wready}, 2'b01);
        tick;
        s0_wvalid = 0;
        #1 chk("t3_b2_valids", {m_awvalid, m_wvalid}, 2'b10);
        chk("t3_b2_awready", s0_awready, 0);
        tick;
        m_awready = 1;
        #1 chk("t3_b3_awready", s0_awready, 1);
        chk("t3_b3_awaddr", m_awaddr, 32'hC);
        tick;
        s0_awvalid = 0; m_bvalid = 1;
        #1 chk("t3_resp_valids", {m_awvalid, m_wvalid}, 2'b00);
        chk("t3_s0_bvalid", s0_bvalid, 1);
        tick;
        m_bvalid = 0;
        #1 chk("t3_aw_count", aw_n - aw0, 1);
        chk("t3_w_count", w_n - w0, 1);
        chk("t3_bvalid_clear", s0_bvalid, 0);

        // 4: s0 write and s1 read in parallel
        s0_awvalid = 1; s0_awaddr = 32'hC; s0_wvalid = 1; s0_wdata = 32'h11112222; s0_wstrb = 4'hF;
        s1_arvalid = 1; s1_araddr = 32'h0;
        tick;
        chk("t4_awaddr", m_awaddr, 32'hC);
        chk("t4_araddr", m_araddr, 32'h0);
        chk("t4_readys", {s0_awready, s0_wready, s1_arready, s1_awready, s1_wready, s0_arready}, 6'b111000);
        tick;
        s0_awvalid = 0; s0_wvalid = 0; s1_arvalid = 0;
        m_bvalid = 1; m_bresp = 2'b10; m_rvalid = 1; m_rdata = 32'h0BADBEEF; m_rresp = 2'b00;
        #1 chk("t4_bvalids", {s0_bvalid, s1_bvalid}, 2'b10);
        chk("t4_s0_bresp", s0_bresp, 2'b10);
        chk("t4_rvalids", {s0_rvalid, s1_rvalid}, 2'b01);
        chk("t4_s1_rdata", s1_rdata, 32'h0BADBEEF);
        tick;
        m_bvalid = 0; m_rvalid = 0; m_bresp = 2'b00;

        // 5: s1 write with back-pressured B while s0 waits for a grant
        s1_awvalid = 1; s1_awaddr = 32'h10; s1_wvalid = 1; s1_wdata = 32'h55AA55AA; s1_wstrb = 4'hF; s1_bready = 0;
        tick;
        chk("t5_s1_awready", s1_awready, 1);
        chk("t5_awaddr", m_awaddr, 32'h10);
        tick;
        s1_awvalid = 0; s1_wvalid = 0; m_bvalid = 1; s0_awvalid = 1; s0_awaddr = 32'h20;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t5_stall_bready", m_bready, 0);
            chk("t5_stall_s1_bvalid", s1_bvalid, 1);
            chk("t5_stall_s0_hold", {s0_awready, m_awvalid}, 2'b00);
            tick;
        end
        s1_bready = 1;
        #1 chk("t5_bready", m_bready, 1);
        tick;
        m_bvalid = 0; s1_bready = 0;
        #1 chk("t5_idle_awvalid", m_awvalid, 0);
        tick;

        // 6: async reset in W_BUSY after AW, before W
        chk("t6_awaddr", m_awaddr, 32'h20);
        chk("t6_aw_only", {m_awvalid, s0_awready, m_wvalid}, 3'b110);
        tick;
        s0_awvalid = 0; s0_wvalid = 1; s0_wdata = 32'h99999999;
        #1 chk("t6_pre_rst", {m_awvalid, m_wvalid, s0_wready}, 3'b011);
        #2 rst = 1;
        #1 chk("t6_rst_async", {m_awvalid, m_wvalid, s0_wready, s0_awready, m_bready, m_arvalid}, 6'b0);
        tick;
        chk("t6_rst_held", {m_wvalid, s0_wready}, 2'b00);
        rst = 0; s0_wvalid = 0;
        tick;
        s0_awvalid = 1; s0_awaddr = 32'h4; s0_wvalid = 1; s0_wdata = 32'hDEADBEEF; s0_bready = 1;
        #1 chk("t6_idle_awvalid", m_awvalid, 0);
        tick;
        chk("t6_fresh_valids", {m_awvalid, m_wvalid}, 2'b11);
        chk("t6_fresh_wdata", m_wdata, 32'hDEADBEEF);
        chk("t6_fresh_awaddr", m_awaddr, 32'h4);
        tick;
        s0_awvalid = 0; s0_wvalid = 0; m_bvalid = 1;
        #1 chk("t6_fresh_bvalid", {s0_bvalid, s1_bvalid}, 2'b10);
        tick;
        m_bvalid = 0;
        #1 chk("t6_fresh_done", s0_bvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end
endmodule
